// File: rtl/ga_pkg.sv
// Shared GA pipeline definitions: population geometry, rank-list entry type
// and the stage FSM state encoding used by selection, crossover and mutation.
package ga_pkg;

    localparam int N_POP  = 50;
    localparam int N_SEL  = 10;
    localparam int PATH_W = 150;
    localparam int FIT_W  = 16;
    localparam int IDX_W  = $clog2(N_POP);
    localparam int SUM_W  = FIT_W + $clog2(N_SEL);

    typedef struct packed {
        logic             valid;
        logic [FIT_W-1:0] fit;
        logic [IDX_W-1:0] idx;
    } rank_entry_t;

    typedef rank_entry_t [N_SEL-1:0] rank_list_t;

    localparam int RANK_LIST_W = $bits(rank_list_t);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        GATHER,
        DONE
    } state_t;

    // Empty entries carry the worst possible fitness so they never outrank a real path.
    function automatic rank_list_t rank_empty();
        rank_list_t lst;
        for (int k = 0; k < N_SEL; k++) begin
            lst[k].valid = 1'b0;
            lst[k].fit   = '1;
            lst[k].idx   = '0;
        end
        return lst;
    endfunction

endpackage

// File: rtl/population_selector_rank_insert.sv
// rank_insert: combinational insertion of one candidate into the ascending
// rank list; entries at and below the insert point shift down, the last drops.
module rank_insert
    import ga_pkg::*;
(
    input  logic [RANK_LIST_W-1:0] list_in,
    input  logic [FIT_W-1:0]       cand_fit,
    input  logic [IDX_W-1:0]       cand_idx,
    output logic [RANK_LIST_W-1:0] list_out
);

    rank_list_t  cur;
    rank_list_t  nxt;
    rank_entry_t cand;
    logic [N_SEL-1:0] ins;

    assign cur      = list_in;
    assign list_out = nxt;

    always_comb begin
        cand.valid = 1'b1;
        cand.fit   = cand_fit;
        cand.idx   = cand_idx;
    end

    // The list is sorted with empty entries last, so ins[] is monotonic: the
    // first set bit is the insert point and every later entry takes its upper neighbour.
    // NOTE: every output gets a full default before any conditional assignment,
    // otherwise the unassigned paths would infer latches.
    always_comb begin
        nxt = cur;
        for (int k = 0; k < N_SEL; k++) begin
            ins[k] = !cur[k].valid || (cur[k].fit > cand_fit);
        end
        if (ins[0]) begin
            nxt[0] = cand;
        end
        for (int k = 1; k < N_SEL; k++) begin
            if (ins[k]) begin
                nxt[k] = ins[k-1] ? cur[k-1] : cand;
            end
        end
    end

endmodule

// File: rtl/population_selector.sv
// GA selection stage: scans N_POP paths one per cycle into a sorted rank list
// and emits the N_SEL fittest paths. Optional stats outputs: SELECTION_STATS_EN.
module population_selector
    import ga_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_POP*PATH_W-1:0] population,
    input  logic [N_POP*FIT_W-1:0]  fitness,
    output logic [N_SEL*PATH_W-1:0] sel_population,
    output logic                    done,
    output logic                    busy
`ifdef SELECTION_STATS_EN
    ,
    output logic [FIT_W-1:0]        best_fit,
    output logic [SUM_W-1:0]        sel_fit_sum
`endif
);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] cand;
    rank_list_t       rank_q;
    logic [RANK_LIST_W-1:0] rank_d;
    logic [FIT_W-1:0] cand_fit;
    logic             clear_list;
    logic             scan_en;
    logic             gather_en;
    logic             done_d;

    assign cand_fit = fitness[int'(cand)*FIT_W +: FIT_W];

    rank_insert u_rank_insert (
        .list_in  (rank_q),
        .cand_fit (cand_fit),
        .cand_idx (cand),
        .list_out (rank_d)
    );

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SCAN;
            SCAN:    if (cand == IDX_W'(N_POP-1)) next_state = GATHER;
            GATHER:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        clear_list = (state == IDLE) && start;
        scan_en    = (state == SCAN);
        gather_en  = (state == GATHER);
        done_d     = (state == DONE);
    end

    // NOTE: the rank list is a handful of flops, not a RAM, so it is reset; its
    // empty contents (invalid, worst fitness) are what the first insertions rely on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rank_q <= rank_empty();
            cand   <= '0;
        end else if (clear_list) begin
            rank_q <= rank_empty();
            cand   <= '0;
        end else if (scan_en) begin
            rank_q <= rank_d;
            if (cand != IDX_W'(N_POP-1)) begin
                cand <= cand + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_population <= '0;
            done           <= 1'b0;
        end else begin
            done <= done_d;
            if (gather_en) begin
                for (int k = 0; k < N_SEL; k++) begin
                    sel_population[k*PATH_W +: PATH_W] <=
                        population[int'(rank_q[k].idx)*PATH_W +: PATH_W];
                end
            end
        end
    end

`ifdef SELECTION_STATS_EN
    logic [SUM_W-1:0] fit_sum;

    always_comb begin
        fit_sum = '0;
        for (int k = 0; k < N_SEL; k++) begin
            fit_sum = fit_sum + SUM_W'(rank_q[k].fit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_fit    <= '0;
            sel_fit_sum <= '0;
        end else if (gather_en) begin
            best_fit    <= rank_q[0].fit;
            sel_fit_sum <= fit_sum;
        end
    end
`endif

endmodule

// File: tb/tb_population_selector.sv
// Directed self-checking bench for population_selector: ranking patterns,
// ties, fixed latency, start-while-busy and mid-scan reset.
module tb_population_selector;
    import ga_pkg::*;

    localparam int LAT = N_POP + 2;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [N_POP*PATH_W-1:0] population;
    logic [N_POP*FIT_W-1:0]  fitness;
    logic [N_SEL*PATH_W-1:0] sel_population;
    logic                    done;
    logic                    busy;
`ifdef SELECTION_STATS_EN
    logic [FIT_W-1:0]        best_fit;
    logic [SUM_W-1:0]        sel_fit_sum;
`endif

    int errors = 0;
    int checks = 0;
    int exp_idx [N_SEL];

    population_selector dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .population     (population),
        .fitness        (fitness),
        .sel_population (sel_population),
        .done           (done),
        .busy           (busy)
`ifdef SELECTION_STATS_EN
        ,
        .best_fit       (best_fit),
        .sel_fit_sum    (sel_fit_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PATH_W-1:0] path_of(input int i);
        logic [PATH_W-1:0] p;
        p      = {PATH_W{i[0]}};
        p[7:0] = i[7:0];
        return p;
    endfunction

    task automatic load_population();
        for (int i = 0; i < N_POP; i++) population[i*PATH_W +: PATH_W] = path_of(i);
    endtask

    // Pulses start, then counts edges until done; lat = -1 if done never comes.
    task automatic run(output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= LAT + 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        population = '0;
        fitness = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", done); end
        checks++;
        if (sel_population !== '0) begin errors++; $display("FAIL reset_sel got=%h want=0", sel_population); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_descending();
        int lat;
        load_population();
        for (int i = 0; i < N_POP; i++) fitness[i*FIT_W +: FIT_W] = 16'(1000 - i);
        run(lat);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL desc_latency got=%0d want=%0d", lat, LAT); end
        for (int k = 0; k < N_SEL; k++) exp_idx[k] = N_POP - 1 - k;
        for (int k = 0; k < N_SEL; k++) begin
            checks++;
            if (sel_population[k*PATH_W +: PATH_W] !== path_of(exp_idx[k])) begin
                errors++;
                $display("FAIL desc_slot%0d got=%h want=%h", k, sel_population[k*PATH_W +: PATH_W], path_of(exp_idx[k]));
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL desc_done_width got=%0b want=0", done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL desc_idle_busy got=%0b want=0", busy); end
    endtask

    task automatic test_ascending();
        int lat;
        for (int i = 0; i < N_POP; i++) fitness[i*FIT_W +: FIT_W] = 16'(i);
        run(lat);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL asc_latency got=%0d want=%0d", lat, LAT); end
        for (int k = 0; k < N_SEL; k++) begin
            checks++;
            if (sel_population[k*PATH_W +: PATH_W] !== path_of(k)) begin
                errors++;
                $display("FAIL asc_slot%0d got=%h want=%h", k, sel_population[k*PATH_W +: PATH_W], path_of(k));
            end
        end
    endtask

    task automatic test_ties();
        int lat;
        for (int i = 0; i < N_POP; i++) fitness[i*FIT_W +: FIT_W] = 16'h0100;
        run(lat);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL ties_latency got=%0d want=%0d", lat, LAT); end
        for (int k = 0; k < N_SEL; k++) begin
            checks++;
            if (sel_population[k*PATH_W +: PATH_W] !== path_of(k)) begin
                errors++;
                $display("FAIL ties_slot%0d got=%h want=%h", k, sel_population[k*PATH_W +: PATH_W], path_of(k));
            end
        end
`ifdef SELECTION_STATS_EN
        checks++;
        if (best_fit !== 16'h0100) begin errors++; $display("FAIL ties_best_fit got=%h want=0100", best_fit); end
        checks++;
        if (sel_fit_sum !== SUM_W'(20'h00A00)) begin errors++; $display("FAIL ties_fit_sum got=%h want=00a00", sel_fit_sum); end
`endif
    endtask

    task automatic test_all_ones();
        int lat;
        for (int i = 0; i < N_POP; i++) fitness[i*FIT_W +: FIT_W] = 16'hFFFF;
        fitness[7*FIT_W +: FIT_W]  = 16'h0000;
        fitness[33*FIT_W +: FIT_W] = 16'h0000;
        exp_idx = '{7, 33, 0, 1, 2, 3, 4, 5, 6, 8};
        run(lat);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL ones_latency got=%0d want=%0d", lat, LAT); end
        for (int k = 0; k < N_SEL; k++) begin
            checks++;
            if (sel_population[k*PATH_W +: PATH_W] !== path_of(exp_idx[k])) begin
                errors++;
                $display("FAIL ones_slot%0d got=%h want=%h", k, sel_population[k*PATH_W +: PATH_W], path_of(exp_idx[k]));
            end
        end
    endtask

    task automatic test_start_while_busy();
        int n_done;
        int first;
        for (int i = 0; i < N_POP; i++) fitness[i*FIT_W +: FIT_W] = 16'(1000 - i);
        n_done = 0;
        first  = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= LAT + 10; c++) begin
            @(posedge clk);
            #1;
            start = (c == 20);
            if (done) begin
                n_done++;
                if (first < 0) first = c;
            end
        end
        start = 1'b0;
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL busy_start_done_count got=%0d want=1", n_done); end
        checks++;
        if (first !== LAT) begin errors++; $display("FAIL busy_start_latency got=%0d want=%0d", first, LAT); end
        checks++;
        if (sel_population[0 +: PATH_W] !== path_of(49)) begin
            errors++;
            $display("FAIL busy_start_slot0 got=%h want=%h", sel_population[0 +: PATH_W], path_of(49));
        end
    endtask

    task automatic test_reset_mid_scan();
        int n_done;
        int lat;
        for (int i = 0; i < N_POP; i++) fitness[i*FIT_W +: FIT_W] = 16'(i);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b want=0", busy); end
        checks++;
        if (sel_population !== '0) begin errors++; $display("FAIL midrst_sel got=%h want=0", sel_population); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < LAT + 10; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        checks++;
        if (n_done !== 0) begin errors++; $display("FAIL midrst_done_count got=%0d want=0", n_done); end
        run(lat);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL midrst_rerun_latency got=%0d want=%0d", lat, LAT); end
        for (int k = 0; k < N_SEL; k++) begin
            checks++;
            if (sel_population[k*PATH_W +: PATH_W] !== path_of(k)) begin
                errors++;
                $display("FAIL midrst_slot%0d got=%h want=%h", k, sel_population[k*PATH_W +: PATH_W], path_of(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_descending();
        test_ascending();
        test_ties();
        test_all_ones();
        test_start_while_busy();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
